// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: maps pixel coordinates to 4-bit RGB and re-times the syncs to match.
// Latency: 2 cycles from x/y/active_in/hsync_in/vsync_in to r/g/b/hsync_o/vsync_o.
// Backpressure: none; the block consumes one pixel per clock and the sync stage never stalls.
//
// Ports:
//   clock, reset            - pixel clock, synchronous active-high reset
//   x, y, active_in         - pixel coordinate and display enable from the sync stage
//   hsync_in, vsync_in      - syncs from the sync stage (polarity set by SYNC_ACTIVE_LOW)
//   mode_req, mode_load     - requested pattern and its 1-cycle capture strobe
//   r, g, b                 - 4-bit colour channels toward the DAC
//   hsync_o, vsync_o        - syncs delayed to line up with r/g/b
//   mode_cur                - pattern being displayed (changes only on a frame event)
//   frame_cnt               - free-running frame counter, +1 per vsync leading edge
module vga_pattern_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int V_VISIBLE       = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode_req,
  input  logic        mode_load,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [1:0]  mode_cur,
  output logic [7:0]  frame_cnt
);

  localparam int          BAR_W     = H_VISIBLE / 8;
  localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [11:0] X_LIM     = 12'(H_VISIBLE);
  localparam logic [11:0] Y_LIM     = 12'(V_VISIBLE);
  localparam logic [11:0] X_LAST    = 12'(H_VISIBLE - 1);
  localparam logic [11:0] Y_LAST    = 12'(V_VISIBLE - 1);

  // ---------------------------------------------------------------------------
  // Frame event: vsync moving from idle to active level.
  // edge_armed suppresses detection on the first cycle after reset, so a vsync
  // that is already active when reset releases is not mistaken for a new frame
  // even though vs_prev itself comes out of reset at the idle level.
  // ---------------------------------------------------------------------------
  logic vs_prev;
  logic edge_armed;
  logic frame_evt;

  assign frame_evt = edge_armed && (vs_prev == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      vs_prev    <= SYNC_IDLE;
      edge_armed <= 1'b0;
    end else begin
      vs_prev    <= vsync_in;
      edge_armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode control and frame counter. A load coinciding with the frame event
  // bypasses the pending register so it takes effect on that same edge.
  // ---------------------------------------------------------------------------
  logic [1:0] pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= 2'd0;
      mode_cur  <= 2'd0;
      frame_cnt <= 8'd0;
    end else begin
      if (mode_load) begin
        pending <= mode_req;
      end
      if (frame_evt) begin
        mode_cur  <= mode_load ? mode_req : pending;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the pixel, syncs and the pattern selection. mode_cur is
  // sampled before its own update, so a pixel in the event cycle keeps the old mode.
  // ---------------------------------------------------------------------------
  logic [11:0] s1_x;
  logic [11:0] s1_y;
  logic        s1_active;
  logic        s1_hs;
  logic        s1_vs;
  logic [1:0]  s1_mode;
  logic [3:0]  s1_fc_hi;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_x      <= 12'd0;
      s1_y      <= 12'd0;
      s1_active <= 1'b0;
      s1_hs     <= SYNC_IDLE;
      s1_vs     <= SYNC_IDLE;
      s1_mode   <= 2'd0;
      s1_fc_hi  <= 4'd0;
    end else begin
      s1_x      <= x;
      s1_y      <= y;
      s1_active <= active_in;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_mode   <= mode_cur;
      s1_fc_hi  <= frame_cnt[7:4];
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern generation from stage-1 values.
  // ---------------------------------------------------------------------------
  logic [2:0] bar_idx;
  logic       s1_visible;
  logic       s1_border;
  logic [3:0] pix_r;
  logic [3:0] pix_g;
  logic [3:0] pix_b;

  // Threshold compare instead of a divider; saturates at bar 7 for x beyond the last bar.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (s1_x >= 12'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
  end

  assign s1_visible = s1_active && (s1_x < X_LIM) && (s1_y < Y_LIM);
  assign s1_border  = (s1_x == 12'd0) || (s1_x == X_LAST) ||
                      (s1_y == 12'd0) || (s1_y == Y_LAST);

  always_comb begin
    pix_r = 4'h0;
    pix_g = 4'h0;
    pix_b = 4'h0;
    case (s1_mode)
      2'd0: begin
        // Inverted index bits give white, yellow, cyan, green, magenta, red, blue, black.
        pix_r = {4{~bar_idx[1]}};
        pix_g = {4{~bar_idx[2]}};
        pix_b = {4{~bar_idx[0]}};
      end
      2'd1: begin
        if (s1_x[5] ^ s1_y[5]) begin
          pix_r = 4'hF;
          pix_g = 4'hF;
          pix_b = 4'hF;
        end
      end
      2'd2: begin
        pix_r = s1_x[7:4];
        pix_g = s1_y[7:4];
        pix_b = s1_fc_hi;
      end
      2'd3: begin
        if (s1_border) begin
          pix_r = 4'hF;
          pix_g = 4'hF;
          pix_b = 4'hF;
        end
      end
      default: begin
        pix_r = 4'h0;
        pix_g = 4'h0;
        pix_b = 4'h0;
      end
    endcase
    if (!s1_visible) begin
      pix_r = 4'h0;
      pix_g = 4'h0;
      pix_b = 4'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r       <= 4'h0;
      g       <= 4'h0;
      b       <= 4'h0;
      hsync_o <= SYNC_IDLE;
      vsync_o <= SYNC_IDLE;
    end else begin
      r       <= pix_r;
      g       <= pix_g;
      b       <= pix_b;
      hsync_o <= s1_hs;
      vsync_o <= s1_vs;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

  logic        clock;
  logic        reset;
  logic [11:0] x;
  logic [11:0] y;
  logic        active_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [1:0]  mode_req;
  logic        mode_load;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hsync_o;
  logic        vsync_o;
  logic [1:0]  mode_cur;
  logic [7:0]  frame_cnt;

  int total;
  int bad;

  vga_pattern_gen dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .active_in (active_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .mode_req  (mode_req),
    .mode_load (mode_load),
    .r         (r),
    .g         (g),
    .b         (b),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .mode_cur  (mode_cur),
    .frame_cnt (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] vx;
    logic [11:0] vy;
    logic        act;
    logic        hs;
    logic [11:0] rgb;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    x         = 12'd0;
    y         = 12'd0;
    active_in = 1'b0;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
  endtask

  // One-cycle vsync pulse; the leading edge is the frame event.
  task automatic vs_pulse();
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick();
  endtask

  // Present a visible pixel, hold it for the pipeline depth, compare RGB.
  task automatic pix(input string name, input logic [11:0] px, input logic [11:0] py,
                     input logic [11:0] exp);
    x         = px;
    y         = py;
    active_in = 1'b1;
    tick();
    tick();
    check(name, {20'd0, r, g, b}, {20'd0, exp});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    mode_req  = 2'd0;
    mode_load = 1'b0;
    idle_inputs();

    //            x        y       act   hs    rgb
    tv[0]  = '{12'd0,   12'd10,  1'b1, 1'b1, 12'hFFF};
    tv[1]  = '{12'd79,  12'd10,  1'b1, 1'b0, 12'hFFF};
    tv[2]  = '{12'd80,  12'd10,  1'b1, 1'b0, 12'hFF0};
    tv[3]  = '{12'd320, 12'd10,  1'b1, 1'b1, 12'hF0F};
    tv[4]  = '{12'd639, 12'd10,  1'b1, 1'b1, 12'h000};
    tv[5]  = '{12'd100, 12'd10,  1'b0, 1'b1, 12'h000};
    tv[6]  = '{12'd700, 12'd10,  1'b1, 1'b0, 12'h000};
    tv[7]  = '{12'd160, 12'd10,  1'b1, 1'b1, 12'h0FF};
    tv[8]  = '{12'd240, 12'd10,  1'b1, 1'b0, 12'h0F0};
    tv[9]  = '{12'd400, 12'd10,  1'b1, 1'b0, 12'hF00};
    tv[10] = '{12'd480, 12'd10,  1'b1, 1'b1, 12'h00F};
    tv[11] = '{12'd50,  12'd480, 1'b1, 1'b0, 12'h000};
    tv[12] = '{12'd100, 12'd10,  1'b1, 1'b1, 12'hFF0};

    // Reset state
    tick();
    tick();
    tick();
    check("rst_rgb", {20'd0, r, g, b}, 32'd0);
    check("rst_hsync", {31'd0, hsync_o}, 32'd1);
    check("rst_vsync", {31'd0, vsync_o}, 32'd1);
    check("rst_mode", {30'd0, mode_cur}, 32'd0);
    check("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Mode 0 bars and blanking, streamed one pixel per clock. Output after
    // the tick of iteration i belongs to the vector driven in iteration i-1.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        x         = tv[i].vx;
        y         = tv[i].vy;
        active_in = tv[i].act;
        hsync_in  = tv[i].hs;
      end else begin
        idle_inputs();
      end
      tick();
      if (i >= 1) begin
        check($sformatf("vec%0d_rgb", i - 1), {20'd0, r, g, b}, {20'd0, tv[i-1].rgb});
        check($sformatf("vec%0d_hsync", i - 1), {31'd0, hsync_o}, {31'd0, tv[i-1].hs});
      end
    end
    idle_inputs();
    tick();
    tick();

    // Mid-frame load of mode 1: no effect until the frame event
    mode_req  = 2'd1;
    mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
    tick();
    tick();
    check("load_hold_mode", {30'd0, mode_cur}, 32'd0);

    // Event cycle carries a pixel: it must render with the old mode (bars,
    // yellow) while the next pixel renders checkerboard (white).
    x         = 12'd100;
    y         = 12'd0;
    active_in = 1'b1;
    vsync_in  = 1'b0;
    tick();
    check("evt_mode", {30'd0, mode_cur}, 32'd1);
    check("evt_fcnt", {24'd0, frame_cnt}, 32'd1);
    vsync_in = 1'b1;
    tick();
    check("evt_pix_old_mode", {20'd0, r, g, b}, 32'hFF0);
    check("evt_vsync_o_low", {31'd0, vsync_o}, 32'd0);
    tick();
    check("post_evt_new_mode", {20'd0, r, g, b}, 32'hFFF);
    check("evt_vsync_o_high", {31'd0, vsync_o}, 32'd1);

    // Checkerboard
    pix("chk_32_0", 12'd32, 12'd0, 12'hFFF);
    pix("chk_32_32", 12'd32, 12'd32, 12'h000);
    pix("chk_0_32", 12'd0, 12'd32, 12'hFFF);

    // Two loads in one frame: the later one wins
    mode_req  = 2'd2;
    mode_load = 1'b1;
    tick();
    mode_req  = 2'd3;
    tick();
    mode_load = 1'b0;
    tick();
    check("two_load_hold", {30'd0, mode_cur}, 32'd1);
    vs_pulse();
    check("two_load_mode", {30'd0, mode_cur}, 32'd3);
    check("two_load_fcnt", {24'd0, frame_cnt}, 32'd2);

    // Border
    pix("bdr_639_200", 12'd639, 12'd200, 12'hFFF);
    pix("bdr_638_200", 12'd638, 12'd200, 12'h000);
    pix("bdr_0_300", 12'd0, 12'd300, 12'hFFF);
    pix("bdr_300_479", 12'd300, 12'd479, 12'hFFF);
    pix("bdr_300_478", 12'd300, 12'd478, 12'h000);
    idle_inputs();

    // Advance the counter to 255
    for (int k = 0; k < 253; k++) begin
      vs_pulse();
    end
    check("fcnt_255", {24'd0, frame_cnt}, 32'd255);
    check("mode_still_3", {30'd0, mode_cur}, 32'd3);

    // Load coinciding with the event applies immediately; counter wraps
    mode_req  = 2'd2;
    mode_load = 1'b1;
    vsync_in  = 1'b0;
    tick();
    check("simul_mode", {30'd0, mode_cur}, 32'd2);
    check("wrap_fcnt", {24'd0, frame_cnt}, 32'd0);
    mode_load = 1'b0;
    vsync_in  = 1'b1;
    tick();

    // Gradient with frame_cnt = 0x35
    for (int k = 0; k < 53; k++) begin
      vs_pulse();
    end
    check("fcnt_53", {24'd0, frame_cnt}, 32'd53);
    check("mode_still_2", {30'd0, mode_cur}, 32'd2);
    hsync_in = 1'b0;
    pix("grad_167_451", 12'd167, 12'd451, 12'hAC3);
    check("grad_hsync_low", {31'd0, hsync_o}, 32'd0);

    // Reset mid-line with vsync held active through release
    reset    = 1'b1;
    vsync_in = 1'b0;
    tick();
    check("mid_rst_rgb", {20'd0, r, g, b}, 32'd0);
    check("mid_rst_hsync", {31'd0, hsync_o}, 32'd1);
    check("mid_rst_vsync", {31'd0, vsync_o}, 32'd1);
    check("mid_rst_fcnt", {24'd0, frame_cnt}, 32'd0);
    check("mid_rst_mode", {30'd0, mode_cur}, 32'd0);
    hsync_in = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_empty", {20'd0, r, g, b}, 32'd0);
    tick();
    check("post_rst_first", {20'd0, r, g, b}, 32'h0FF);
    check("post_rst_vsync_o", {31'd0, vsync_o}, 32'd0);
    tick();
    tick();
    tick();
    check("held_vs_no_evt", {24'd0, frame_cnt}, 32'd0);
    vsync_in = 1'b1;
    tick();
    vs_pulse();
    check("evt_after_rst", {24'd0, frame_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
